// File: rtl/cg_vector_writeback_pkg.sv
// Shared types, defaults and helpers for the CG vector writeback stage.
// State encoding and the word-count helper live here so sub-blocks agree.
package cg_pkg;

    localparam int CG_ELEMENT_WIDTH = 32;
    localparam int CG_NO_OF_UNITS   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XR   = 2'd1;
    localparam logic [1:0] ST_P    = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The 33-bit intermediate keeps n + d - 1 from wrapping.
    function automatic logic [31:0] cg_ceil_div(
        input logic [31:0] n,
        input logic [31:0] d
    );
        logic [32:0] num;
        logic [32:0] quo;
        num = {1'b0, n} + {1'b0, d} - 33'd1;
        quo = num / {1'b0, d};
        return quo[31:0];
    endfunction

endpackage

// File: rtl/cg_vector_writeback_if.sv
// Handshake/data bundle between the CG ALU wrapper and the writeback stage.
// master drives ALU results and control, slave drives the memory ports.
interface cg_vector_writeback_if #(
    parameter int element_width          = 32,
    parameter int no_of_units            = 8,
    parameter int memories_address_width = 32,
    parameter int iter_width             = 16
);
    localparam int LW = element_width * no_of_units;
    localparam int AW = memories_address_width;

    logic                  start;
    logic [31:0]           total;
    logic [iter_width-1:0] max_iter;
    logic                  converged;
    logic                  xr_valid;
    logic                  p_valid;
    logic [LW-1:0]         x_in;
    logic [LW-1:0]         r_in;
    logic [LW-1:0]         p_in;

    logic                  mem_x_we;
    logic                  mem_r_we;
    logic                  mem_rprev_we;
    logic                  mem_p_we;
    logic [AW-1:0]         mem_wr_addr_xr;
    logic [AW-1:0]         mem_wr_addr_p;
    logic [LW-1:0]         mem_x_data;
    logic [LW-1:0]         mem_r_data;
    logic [LW-1:0]         mem_p_data;
    logic                  xr_done;
    logic                  p_done;
    logic [iter_width-1:0] iteration;
    logic                  busy;
    logic                  finish_all;
    logic                  phase_err;

    modport master (
        output start, total, max_iter, converged,
        output xr_valid, p_valid, x_in, r_in, p_in,
        input  mem_x_we, mem_r_we, mem_rprev_we, mem_p_we,
        input  mem_wr_addr_xr, mem_wr_addr_p,
        input  mem_x_data, mem_r_data, mem_p_data,
        input  xr_done, p_done, iteration,
        input  busy, finish_all, phase_err
    );

    modport slave (
        input  start, total, max_iter, converged,
        input  xr_valid, p_valid, x_in, r_in, p_in,
        output mem_x_we, mem_r_we, mem_rprev_we, mem_p_we,
        output mem_wr_addr_xr, mem_wr_addr_p,
        output mem_x_data, mem_r_data, mem_p_data,
        output xr_done, p_done, iteration,
        output busy, finish_all, phase_err
    );

endinterface

// File: rtl/cg_wb_addr_gen.sv
// Word address counter for one writeback phase.
// Wraps to 0 after the beat at words_i-1 and flags that last beat.
module cg_wb_addr_gen
    import cg_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic [AW-1:0] words_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    assign addr_o = addr_q;
    assign last_o = (addr_q == words_i - AW'(1));

    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (adv_i) begin
            addr_d = last_o ? '0 : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

endmodule

// File: rtl/cg_vector_writeback.sv
// CG writeback stage: X/R then P vector memory writes per iteration.
// Define CG_WB_ZERO_PAD_EN to zero the unused lanes of the last word.
module cg_vector_writeback
    import cg_pkg::*;
#(
    parameter int element_width          = CG_ELEMENT_WIDTH,
    parameter int no_of_units            = CG_NO_OF_UNITS,
    parameter int memories_address_width = 32,
    parameter int iter_width             = 16
) (
    input  logic clk,
    input  logic reset,
    cg_vector_writeback_if.slave bus
);

    localparam int LW = element_width * no_of_units;
    localparam int AW = memories_address_width;
    localparam int IW = iter_width;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] words_q, words_d;
    logic [IW-1:0] max_q, max_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          xwe_q, xwe_d;
    logic          pwe_q, pwe_d;
    logic [AW-1:0] axr_q, axr_d;
    logic [AW-1:0] ap_q, ap_d;
    logic [LW-1:0] xd_q, xd_d;
    logic [LW-1:0] rd_q, rd_d;
    logic [LW-1:0] pd_q, pd_d;
    logic          xdone_q, xdone_d;
    logic          pdone_q, pdone_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;

    logic          idle, go, rej;
    logic          xr_acc, p_acc, xr_bad, p_bad;
    logic [AW-1:0] xr_addr, p_addr;
    logic          xr_last, p_last;
    logic [31:0]   tw;
    logic [IW-1:0] iter_nx;
    logic [LW-1:0] x_pad, r_pad, p_pad;

    assign idle   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign rej    = idle && bus.start &&
                    (bus.total == '0 || bus.max_iter == '0);
    assign go     = idle && bus.start && !rej;
    assign xr_acc = (state_q == ST_XR) && bus.xr_valid;
    assign p_acc  = (state_q == ST_P) && bus.p_valid;
    assign xr_bad = bus.xr_valid && (state_q != ST_XR);
    assign p_bad  = bus.p_valid && (state_q != ST_P);
    assign tw      = cg_ceil_div(bus.total, 32'(no_of_units));
    assign iter_nx = iter_q + IW'(1);

    cg_wb_addr_gen #(.AW(AW)) u_xr_addr (
        .clk     (clk),
        .rst     (reset),
        .clr_i   (go),
        .adv_i   (xr_acc),
        .words_i (words_q),
        .addr_o  (xr_addr),
        .last_o  (xr_last)
    );

    cg_wb_addr_gen #(.AW(AW)) u_p_addr (
        .clk     (clk),
        .rst     (reset),
        .clr_i   (go),
        .adv_i   (p_acc),
        .words_i (words_q),
        .addr_o  (p_addr),
        .last_o  (p_last)
    );

`ifdef CG_WB_ZERO_PAD_EN
    // Number of live lanes in the final word, 1..no_of_units.
    logic [31:0] keep_q, keep_d;

    assign keep_d = go ?
        bus.total - (tw - 32'd1) * 32'(no_of_units) : keep_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) keep_q <= '0;
        else       keep_q <= keep_d;
    end

    always_comb begin
        x_pad = bus.x_in;
        r_pad = bus.r_in;
        p_pad = bus.p_in;
        for (int i = 0; i < no_of_units; i++) begin
            if (32'(i) >= keep_q) begin
                if (xr_last) begin
                    x_pad[i*element_width +: element_width] = '0;
                    r_pad[i*element_width +: element_width] = '0;
                end
                if (p_last) begin
                    p_pad[i*element_width +: element_width] = '0;
                end
            end
        end
    end
`else
    assign x_pad = bus.x_in;
    assign r_pad = bus.r_in;
    assign p_pad = bus.p_in;
`endif

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        max_d   = max_q;
        iter_d  = iter_q;
        xwe_d   = 1'b0;
        pwe_d   = 1'b0;
        axr_d   = axr_q;
        ap_d    = ap_q;
        xd_d    = xd_q;
        rd_d    = rd_q;
        pd_d    = pd_q;
        xdone_d = 1'b0;
        pdone_d = 1'b0;
        fin_d   = fin_q | (state_q == ST_DONE);
        err_d   = err_q | xr_bad | p_bad | rej;

        if (go) begin
            state_d = ST_XR;
            words_d = AW'(tw);
            max_d   = bus.max_iter;
            iter_d  = '0;
            axr_d   = '0;
            ap_d    = '0;
            fin_d   = 1'b0;
            err_d   = xr_bad | p_bad;
        end

        if (xr_acc) begin
            xwe_d   = 1'b1;
            axr_d   = xr_addr;
            xd_d    = x_pad;
            rd_d    = r_pad;
            xdone_d = xr_last;
            if (xr_last) state_d = ST_P;
        end

        if (p_acc) begin
            pwe_d   = 1'b1;
            ap_d    = p_addr;
            pd_d    = p_pad;
            pdone_d = p_last;
            if (p_last) begin
                iter_d = iter_nx;
                // Converged level is only sampled on the closing P beat.
                if (bus.converged || iter_nx == max_q) state_d = ST_DONE;
                else                                   state_d = ST_XR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            max_q   <= '0;
            iter_q  <= '0;
            xwe_q   <= 1'b0;
            pwe_q   <= 1'b0;
            axr_q   <= '0;
            ap_q    <= '0;
            xd_q    <= '0;
            rd_q    <= '0;
            pd_q    <= '0;
            xdone_q <= 1'b0;
            pdone_q <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            max_q   <= max_d;
            iter_q  <= iter_d;
            xwe_q   <= xwe_d;
            pwe_q   <= pwe_d;
            axr_q   <= axr_d;
            ap_q    <= ap_d;
            xd_q    <= xd_d;
            rd_q    <= rd_d;
            pd_q    <= pd_d;
            xdone_q <= xdone_d;
            pdone_q <= pdone_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_x_we       = xwe_q;
    assign bus.mem_r_we       = xwe_q;
    assign bus.mem_rprev_we   = xwe_q;
    assign bus.mem_p_we       = pwe_q;
    assign bus.mem_wr_addr_xr = axr_q;
    assign bus.mem_wr_addr_p  = ap_q;
    assign bus.mem_x_data     = xd_q;
    assign bus.mem_r_data     = rd_q;
    assign bus.mem_p_data     = pd_q;
    assign bus.xr_done        = xdone_q;
    assign bus.p_done         = pdone_q;
    assign bus.iteration      = iter_q;
    assign bus.busy           = (state_q == ST_XR) || (state_q == ST_P);
    assign bus.finish_all     = fin_q;
    assign bus.phase_err      = err_q;

endmodule

// File: tb/tb_cg_vector_writeback.sv
// Directed testbench for cg_vector_writeback.
// Honours CG_WB_ZERO_PAD_EN when choosing last-word expectations.
module tb_cg_vector_writeback;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // Keeps lanes 0..4, clears lanes 5..7 (total=13 -> 5 live lanes).
    logic [255:0] m5;

    cg_vector_writeback_if bus ();

    cg_vector_writeback dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] vec(input logic [7:0] tag);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {tag, 8'h5A, 16'(i + 1)};
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start     = 1'b0;
        bus.total     = '0;
        bus.max_iter  = '0;
        bus.converged = 1'b0;
        bus.xr_valid  = 1'b0;
        bus.p_valid   = 1'b0;
        bus.x_in      = '0;
        bus.r_in      = '0;
        bus.p_in      = '0;
    endtask

    task automatic do_start(input logic [31:0] tot, input logic [15:0] mi);
        bus.start    = 1'b1;
        bus.total    = tot;
        bus.max_iter = mi;
        cyc();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL rst x_we got %0b want 0", bus.mem_x_we); end
        n_cmp++; if (bus.mem_p_we !== 1'b0) begin n_bad++; $display("FAIL rst p_we got %0b want 0", bus.mem_p_we); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.iteration !== 16'd0) begin n_bad++; $display("FAIL rst iter got %0d want 0", bus.iteration); end
        n_cmp++; if (bus.finish_all !== 1'b0) begin n_bad++; $display("FAIL rst fin got %0b want 0", bus.finish_all); end
        n_cmp++; if (bus.phase_err !== 1'b0) begin n_bad++; $display("FAIL rst err got %0b want 0", bus.phase_err); end
    endtask

    task automatic test_exact();
        do_start(32'd16, 16'd1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ex busy got %0b want 1", bus.busy); end
        bus.xr_valid = 1'b1; bus.x_in = vec(8'hA1); bus.r_in = vec(8'hB1);
        cyc();
        n_cmp++; if (bus.mem_x_we !== 1'b1) begin n_bad++; $display("FAIL ex x_we0 got %0b want 1", bus.mem_x_we); end
        n_cmp++; if (bus.mem_rprev_we !== 1'b1) begin n_bad++; $display("FAIL ex rp_we0 got %0b want 1", bus.mem_rprev_we); end
        n_cmp++; if (bus.mem_wr_addr_xr !== 32'd0) begin n_bad++; $display("FAIL ex axr0 got %0d want 0", bus.mem_wr_addr_xr); end
        n_cmp++; if (bus.mem_r_data !== vec(8'hB1)) begin n_bad++; $display("FAIL ex rdat0 got %h want %h", bus.mem_r_data, vec(8'hB1)); end
        n_cmp++; if (bus.xr_done !== 1'b0) begin n_bad++; $display("FAIL ex xdone0 got %0b want 0", bus.xr_done); end
        bus.x_in = vec(8'hA2);
        cyc();
        n_cmp++; if (bus.mem_wr_addr_xr !== 32'd1) begin n_bad++; $display("FAIL ex axr1 got %0d want 1", bus.mem_wr_addr_xr); end
        n_cmp++; if (bus.mem_x_data !== vec(8'hA2)) begin n_bad++; $display("FAIL ex xdat1 got %h want %h", bus.mem_x_data, vec(8'hA2)); end
        n_cmp++; if (bus.xr_done !== 1'b1) begin n_bad++; $display("FAIL ex xdone1 got %0b want 1", bus.xr_done); end
        bus.xr_valid = 1'b0; bus.p_valid = 1'b1; bus.p_in = vec(8'hC1);
        cyc();
        n_cmp++; if (bus.mem_p_we !== 1'b1) begin n_bad++; $display("FAIL ex p_we0 got %0b want 1", bus.mem_p_we); end
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL ex x_we_p got %0b want 0", bus.mem_x_we); end
        n_cmp++; if (bus.mem_wr_addr_p !== 32'd0) begin n_bad++; $display("FAIL ex ap0 got %0d want 0", bus.mem_wr_addr_p); end
        n_cmp++; if (bus.p_done !== 1'b0) begin n_bad++; $display("FAIL ex pdone0 got %0b want 0", bus.p_done); end
        bus.p_in = vec(8'hC2);
        cyc();
        n_cmp++; if (bus.mem_wr_addr_p !== 32'd1) begin n_bad++; $display("FAIL ex ap1 got %0d want 1", bus.mem_wr_addr_p); end
        n_cmp++; if (bus.p_done !== 1'b1) begin n_bad++; $display("FAIL ex pdone1 got %0b want 1", bus.p_done); end
        n_cmp++; if (bus.iteration !== 16'd1) begin n_bad++; $display("FAIL ex iter got %0d want 1", bus.iteration); end
        n_cmp++; if (bus.finish_all !== 1'b0) begin n_bad++; $display("FAIL ex fin_early got %0b want 0", bus.finish_all); end
        bus.p_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.finish_all !== 1'b1) begin n_bad++; $display("FAIL ex fin got %0b want 1", bus.finish_all); end
        n_cmp++; if (bus.mem_p_we !== 1'b0) begin n_bad++; $display("FAIL ex p_we_end got %0b want 0", bus.mem_p_we); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ex busy_end got %0b want 0", bus.busy); end
    endtask

    task automatic test_partial();
        logic [255:0] ex, er, ep;
`ifdef CG_WB_ZERO_PAD_EN
        ex = vec(8'hA4) & m5; er = vec(8'hB4) & m5; ep = vec(8'hC4) & m5;
`else
        ex = vec(8'hA4); er = vec(8'hB4); ep = vec(8'hC4);
`endif
        do_start(32'd13, 16'd1);
        n_cmp++; if (bus.finish_all !== 1'b0) begin n_bad++; $display("FAIL pt fin_clr got %0b want 0", bus.finish_all); end
        bus.xr_valid = 1'b1; bus.x_in = vec(8'hA3); bus.r_in = vec(8'hB3);
        cyc();
        n_cmp++; if (bus.mem_x_data !== vec(8'hA3)) begin n_bad++; $display("FAIL pt xdat0 got %h want %h", bus.mem_x_data, vec(8'hA3)); end
        n_cmp++; if (bus.xr_done !== 1'b0) begin n_bad++; $display("FAIL pt xdone0 got %0b want 0", bus.xr_done); end
        bus.x_in = vec(8'hA4); bus.r_in = vec(8'hB4);
        cyc();
        n_cmp++; if (bus.mem_x_data !== ex) begin n_bad++; $display("FAIL pt xdat1 got %h want %h", bus.mem_x_data, ex); end
        n_cmp++; if (bus.mem_r_data !== er) begin n_bad++; $display("FAIL pt rdat1 got %h want %h", bus.mem_r_data, er); end
        n_cmp++; if (bus.xr_done !== 1'b1) begin n_bad++; $display("FAIL pt xdone1 got %0b want 1", bus.xr_done); end
        bus.xr_valid = 1'b0; bus.p_valid = 1'b1; bus.p_in = vec(8'hC3);
        cyc();
        n_cmp++; if (bus.mem_p_data !== vec(8'hC3)) begin n_bad++; $display("FAIL pt pdat0 got %h want %h", bus.mem_p_data, vec(8'hC3)); end
        bus.p_in = vec(8'hC4);
        cyc();
        n_cmp++; if (bus.mem_p_data !== ep) begin n_bad++; $display("FAIL pt pdat1 got %h want %h", bus.mem_p_data, ep); end
        n_cmp++; if (bus.p_done !== 1'b1) begin n_bad++; $display("FAIL pt pdone got %0b want 1", bus.p_done); end
        bus.p_valid = 1'b0;
        cyc();
    endtask

    task automatic test_converge();
        do_start(32'd8, 16'd5);
        bus.xr_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.xr_done !== 1'b1) begin n_bad++; $display("FAIL cv xdone1 got %0b want 1", bus.xr_done); end
        bus.xr_valid = 1'b0; bus.p_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.iteration !== 16'd1) begin n_bad++; $display("FAIL cv iter1 got %0d want 1", bus.iteration); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL cv busy1 got %0b want 1", bus.busy); end
        bus.p_valid = 1'b0; bus.xr_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.mem_x_we !== 1'b1) begin n_bad++; $display("FAIL cv x_we2 got %0b want 1", bus.mem_x_we); end
        bus.xr_valid = 1'b0; bus.p_valid = 1'b1; bus.converged = 1'b1;
        cyc();
        n_cmp++; if (bus.iteration !== 16'd2) begin n_bad++; $display("FAIL cv iter2 got %0d want 2", bus.iteration); end
        bus.p_valid = 1'b0; bus.converged = 1'b0; bus.xr_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.finish_all !== 1'b1) begin n_bad++; $display("FAIL cv fin got %0b want 1", bus.finish_all); end
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL cv x_we_after got %0b want 0", bus.mem_x_we); end
        n_cmp++; if (bus.phase_err !== 1'b1) begin n_bad++; $display("FAIL cv err got %0b want 1", bus.phase_err); end
        bus.xr_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.iteration !== 16'd2) begin n_bad++; $display("FAIL cv iter_hold got %0d want 2", bus.iteration); end
    endtask

    task automatic test_wrong_phase();
        do_start(32'd8, 16'd1);
        n_cmp++; if (bus.phase_err !== 1'b0) begin n_bad++; $display("FAIL wp err_clr got %0b want 0", bus.phase_err); end
        bus.p_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.mem_p_we !== 1'b0) begin n_bad++; $display("FAIL wp p_we got %0b want 0", bus.mem_p_we); end
        n_cmp++; if (bus.phase_err !== 1'b1) begin n_bad++; $display("FAIL wp err got %0b want 1", bus.phase_err); end
        bus.p_valid = 1'b0; bus.xr_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.mem_x_we !== 1'b1) begin n_bad++; $display("FAIL wp x_we got %0b want 1", bus.mem_x_we); end
        n_cmp++; if (bus.phase_err !== 1'b1) begin n_bad++; $display("FAIL wp err_hold got %0b want 1", bus.phase_err); end
        bus.p_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.mem_p_we !== 1'b1) begin n_bad++; $display("FAIL wp both_p got %0b want 1", bus.mem_p_we); end
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL wp both_x got %0b want 0", bus.mem_x_we); end
        bus.p_valid = 1'b0; bus.xr_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.finish_all !== 1'b1) begin n_bad++; $display("FAIL wp fin got %0b want 1", bus.finish_all); end
        n_cmp++; if (bus.phase_err !== 1'b1) begin n_bad++; $display("FAIL wp err_end got %0b want 1", bus.phase_err); end
    endtask

    task automatic test_async_reset();
        do_start(32'd24, 16'd1);
        bus.xr_valid = 1'b1; bus.x_in = vec(8'hA5);
        cyc();
        n_cmp++; if (bus.mem_x_we !== 1'b1) begin n_bad++; $display("FAIL ar x_we0 got %0b want 1", bus.mem_x_we); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL ar x_we_rst got %0b want 0", bus.mem_x_we); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ar busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.mem_x_data !== 256'd0) begin n_bad++; $display("FAIL ar xdat got %h want 0", bus.mem_x_data); end
        cyc();
        n_cmp++; if (bus.mem_x_we !== 1'b0) begin n_bad++; $display("FAIL ar x_we_hold got %0b want 0", bus.mem_x_we); end
        rst = 1'b0; bus.xr_valid = 1'b0;
        do_start(32'd24, 16'd1);
        bus.xr_valid = 1'b1;
        cyc();
        n_cmp++; if (bus.mem_wr_addr_xr !== 32'd0) begin n_bad++; $display("FAIL ar axr_re got %0d want 0", bus.mem_wr_addr_xr); end
        n_cmp++; if (bus.mem_x_we !== 1'b1) begin n_bad++; $display("FAIL ar x_we_re got %0b want 1", bus.mem_x_we); end
        cyc();
        n_cmp++; if (bus.mem_wr_addr_xr !== 32'd1) begin n_bad++; $display("FAIL ar axr_re1 got %0d want 1", bus.mem_wr_addr_xr); end
        bus.xr_valid = 1'b0;
    endtask

    task automatic test_reject();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        do_start(32'd0, 16'd3);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rj busy_t0 got %0b want 0", bus.busy); end
        n_cmp++; if (bus.phase_err !== 1'b1) begin n_bad++; $display("FAIL rj err_t0 got %0b want 1", bus.phase_err); end
        do_start(32'd8, 16'd0);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rj busy_m0 got %0b want 0", bus.busy); end
        do_start(32'd8, 16'd1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rj busy_ok got %0b want 1", bus.busy); end
        n_cmp++; if (bus.phase_err !== 1'b0) begin n_bad++; $display("FAIL rj err_ok got %0b want 0", bus.phase_err); end
        // A re-latch to total=16 would make this beat non-final.
        bus.start = 1'b1; bus.total = 32'd16; bus.max_iter = 16'd1; bus.xr_valid = 1'b1;
        cyc();
        bus.start = 1'b0; bus.xr_valid = 1'b0;
        n_cmp++; if (bus.xr_done !== 1'b1) begin n_bad++; $display("FAIL rj busy_start got %0b want 1", bus.xr_done); end
        n_cmp++; if (bus.phase_err !== 1'b0) begin n_bad++; $display("FAIL rj err_busy got %0b want 0", bus.phase_err); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m5 = {96'd0, {160{1'b1}}};
        rst = 1'b1;
        idle_in();
        #12;
        test_reset();
        rst = 1'b0;
        cyc();
        test_exact();
        test_partial();
        test_converge();
        test_wrong_phase();
        test_async_reset();
        test_reject();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cg_vector_writeback.md
Name: cg_vector_writeback

Overview:
- Downstream stage of the CG ALU wrapper.
- Takes the ALU's per-beat X/R and P results (no_of_units lanes per beat) and drives the X, R, Rprev and P vector memories with write addresses and enables.
- Sequences one CG iteration as an X/R update phase followed by a P update phase.
- Counts iterations and asserts finish_all on convergence or when the iteration limit is reached.

Parameters:
- element_width, 32, bits per vector element.
- no_of_units, 8, elements (lanes) per memory word/beat.
- memories_address_width, 32, width of memory word addresses.
- iter_width, 16, width of the iteration counter and max_iter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a solve.
- total  input  32  vector length in elements; sampled on start.
- max_iter  input  iter_width  iteration limit; sampled on start.
- converged  input  1  level from the residual check; sampled at end of P phase.
- xr_valid  input  1  X/R result beat valid (ALU we_4).
- p_valid  input  1  P result beat valid (ALU we_5).
- x_in, r_in, p_in  input  element_width*no_of_units  ALU result lanes.
- mem_x_we, mem_r_we, mem_rprev_we, mem_p_we  output  1  memory write enables.
- mem_wr_addr_xr, mem_wr_addr_p  output  memories_address_width  word write addresses.
- mem_x_data, mem_r_data, mem_p_data  output  element_width*no_of_units  write data.
- xr_done, p_done  output  1  one-cycle phase-complete pulses.
- iteration  output  iter_width  completed iterations.
- busy  output  1  high in XR or P phase.
- finish_all  output  1  solve complete; held until the next start.
- phase_err  output  1  sticky: a beat arrived outside its phase.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Derived length: total_words = ceil(total/no_of_units), latched on start.
- Start rejection: start with total==0 or max_iter==0 is ignored and sets phase_err.
- States: IDLE, XR, P, DONE.
- IDLE/DONE + start → XR; clears iteration, both addresses and finish_all.
- start while busy: ignored.
- XR phase, per xr_valid beat:
  - Registered, latency 1: mem_x_we = mem_r_we = mem_rprev_we = 1, mem_wr_addr_xr = current address, data = x_in/r_in.
  - Address then increments.
  - On the beat at address total_words-1: xr_done pulses in the same cycle as the write; address wraps to 0; go to P.
- P phase: same rules with p_valid, mem_p_we, mem_wr_addr_p, p_done.
- On the last P beat: iteration increments.
  - If converged==1, or the new iteration == max_iter: go to DONE and assert finish_all in the cycle after the last write.
  - Otherwise return to XR.
- Wrong-phase beats: xr_valid outside XR, or p_valid outside P, produces no write and sets phase_err. phase_err clears only on reset or on an accepted start.
- xr_valid and p_valid together: only the one matching the current phase is accepted; the other sets phase_err.
- Write enables are single-cycle, one per accepted beat. Data and address are held between beats; their values are don't-care while we is 0.
- Reset mid-phase: immediate return to IDLE, with no further writes.

Optional Feature:
- Macro: CG_WB_ZERO_PAD_EN.
- Defined: on the last word, lanes with index ≥ total − (total_words−1)*no_of_units are forced to 0 in mem_x_data, mem_r_data and mem_p_data. Lane 0 is bits [element_width-1:0].
- Undefined: data passes through unmodified.

Decomposition:
- Shared package cg_pkg holds:
  - The state encoding (IDLE=0, XR=1, P=2, DONE=3).
  - Default element_width and no_of_units.
  - A ceil-divide function for total_words.
- One natural sub-module: cg_wb_addr_gen.
  - An address counter with wrap at total_words-1 and a last-beat flag.
  - Instantiated twice, once for XR and once for P.

Test Plan:
- Exact-multiple length, one iteration: total=16, max_iter=1, 2 xr beats then 2 p beats.
  - Writes at addresses 0,1 in each phase.
  - xr_done and p_done each pulse once.
  - iteration=1; finish_all=1 one cycle after the last p write.
- Partial last word: total=13, with zero-pad enabled.
  - 2 words per phase.
  - Word 1 lanes 5..7 read 0; lanes 0..4 pass through.
  - Without the macro, all lanes pass.
- Convergence stop: total=8, max_iter=5, converged=1 during the 2nd P phase.
  - Stops with iteration=2 and finish_all=1.
  - No XR writes follow.
- Wrong-phase beat: p_valid during XR.
  - No mem_p_we.
  - phase_err=1 and stays set until the next start.
- Asynchronous reset asserted mid-XR after 1 of 3 beats.
  - All outputs 0 immediately; no further writes.
  - A new start writes again from address 0.
- Rejected starts: start with total=0.
  - State stays IDLE; phase_err=1.
  - A start while busy is ignored.
